// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
package uart_pkg;

    localparam int unsigned UART_DATA_W         = 8;
    localparam int unsigned DEFAULT_DEPTH       = 16;
    localparam int unsigned DEFAULT_ACK_TIMEOUT = 4;

    // Launch FSM states.
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitRise = 2'd1,
        StWaitFall = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for the transmit FIFO: one write port, one asynchronous read port.
module sync_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write; contents are not cleared by reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter: buffers host writes and launches one byte at a
// time with a start pulse, waiting for the transmitter to finish (or fail to respond).
module uart_tx_fifo import uart_pkg::*; #(
    parameter int unsigned DATA_W      = UART_DATA_W,
    parameter int unsigned DEPTH       = DEFAULT_DEPTH,
    parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     clr_ovf,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned TW     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]     TimerLast = TW'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W:0]   CountFull = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q, overflow_q;
    logic [DATA_W-1:0] tx_data_q, head;
    logic              tx_start_q;
    logic [TW-1:0]     timer_q, timer_d;
    tx_state_e         state_q, state_d;
    logic              push, pop;

    // wr_ready comes straight from the registered full flag, so a full FIFO never takes a byte
    // even when a pop happens in the same cycle.
    assign push = wr_valid & ~full_q;

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!empty_q && !tx_busy) state_d = StWaitRise;
            end
            StWaitRise: begin
                if (tx_busy) begin
                    state_d = StWaitFall;
                end else if (timer_q == TimerLast) begin
                    // Transmitter never acknowledged; treat the byte as sent.
                    state_d = StIdle;
                end
            end
            StWaitFall: begin
                if (!tx_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: pop strobe and acknowledge timer.
    always_comb begin
        pop     = 1'b0;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (!empty_q && !tx_busy) begin
                    pop     = 1'b1;
                    timer_d = '0;
                end
            end
            StWaitRise: begin
                if (!tx_busy) timer_d = timer_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Occupancy next-state; count is kept separately so full and empty are unambiguous.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers, flags, timer and the registered transmitter outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                tx_data_q <= head;
            end
            tx_start_q <= pop;
            timer_q    <= timer_d;
            count_q    <= count_d;
            full_q     <= (count_d == CountFull);
            empty_q    <= (count_d == '0);
            // Setting takes priority over clearing.
            if (wr_valid && full_q) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign wr_ready = ~full_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for the single-byte and push/pop cases, plus
// hand-written sequences for bursts, overflow, wrap-around and reset mid-frame.
module tb_uart_tx_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       clr_ovf;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Transmitter model state.
    logic model_on = 1'b0;
    logic model_busy = 1'b0;
    logic man_busy = 1'b0;
    int   busy_left = 0;
    int   cyc = 0;
    logic prev_start = 1'b0;
    logic [7:0] launch_dat[$];
    int         launch_cyc[$];

    assign tx_busy = model_on ? model_busy : man_busy;

    uart_tx_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .clr_ovf  (clr_ovf),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Transmitter model and launch monitor: busy rises the cycle after tx_start, lasts 10 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy_left > 0) begin
                model_busy = 1'b1;
                busy_left--;
            end else begin
                model_busy = 1'b0;
            end
            if (tx_start) begin
                if (model_on) busy_left = 10;
                chk("start_not_consecutive", {31'd0, prev_start}, 32'd0);
                launch_dat.push_back(tx_data);
                launch_cyc.push_back(cyc);
            end
            prev_start = tx_start;
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        clr_ovf  = 1'b0;
        step();
        reset = 1'b0;
        launch_dat.delete();
        launch_cyc.delete();
    endtask

    task automatic wait_launches(input int n, input int budget, input string name);
        int b;
        b = budget;
        while (launch_dat.size() < n && b > 0) begin
            step();
            b--;
        end
        chk(name, launch_dat.size(), n);
    endtask

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       busy;
        logic       clr;
        logic [4:0] e_count;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic       e_start;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int  n_first;
        int  nxt;
        int  budget;
        int  max_cnt;
        logic acc;

        // Inputs applied in one cycle; expectations observed in the following cycle.
        vecs[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55};
        vecs[2]  = '{1'b1, 8'h66, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h66};
        vecs[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66};
        vecs[10] = '{1'b1, 8'h88, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77};

        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        clr_ovf  = 1'b0;
        step();
        step();
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;

        // Vector table: single byte with timeout, relaunch after timeout, busy handshake,
        // simultaneous push and pop at count 1.
        model_on = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wr_valid = vecs[i].wv;
            wr_data  = vecs[i].wd;
            man_busy = vecs[i].busy;
            clr_ovf  = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_count", i), count, vecs[i].e_count);
            chk($sformatf("vec%0d_full", i), full, vecs[i].e_full);
            chk($sformatf("vec%0d_wr_ready", i), wr_ready, !vecs[i].e_full);
            chk($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
            chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].e_ovf);
            chk($sformatf("vec%0d_tx_start", i), tx_start, vecs[i].e_start);
            chk($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].e_data);
        end
        wr_valid = 1'b0;
        clr_ovf  = 1'b0;
        man_busy = 1'b0;

        // Three-byte burst against a transmitter that holds busy for 10 cycles.
        do_reset();
        busy_left = 0;
        model_on  = 1'b1;
        n_first   = cyc;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h41 + 8'(i);
            step();
        end
        wr_valid = 1'b0;
        wait_launches(3, 100, "burst_launch_count");
        if (launch_dat.size() == 3) begin
            chk("burst_first_latency", launch_cyc[0] - n_first, 2);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("burst_data%0d", i), launch_dat[i], 8'h41 + 8'(i));
            end
            chk("burst_gap01", launch_cyc[1] - launch_cyc[0], 13);
            chk("burst_gap12", launch_cyc[2] - launch_cyc[1], 13);
        end

        // Overflow: busy stuck high, 17 pushes into 16 entries.
        do_reset();
        model_on = 1'b0;
        man_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hA0 + 8'(i);
            step();
            if (i == 15) begin
                chk("fill16_full", full, 1);
                chk("fill16_overflow", overflow, 0);
            end
        end
        chk("ovf_count", count, 16);
        chk("ovf_full", full, 1);
        chk("ovf_wr_ready", wr_ready, 0);
        chk("ovf_overflow", overflow, 1);
        clr_ovf = 1'b1;
        step();
        chk("ovf_set_wins", overflow, 1);
        wr_valid = 1'b0;
        step();
        chk("ovf_cleared", overflow, 0);
        clr_ovf  = 1'b0;
        man_busy = 1'b0;
        wait_launches(16, 200, "drain_launch_count");
        if (launch_dat.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("drain_data%0d", i), launch_dat[i], 8'hA0 + 8'(i));
            end
            chk("timeout_gap", launch_cyc[1] - launch_cyc[0], 5);
        end
        for (int i = 0; i < 10; i++) step();
        chk("drain_no_extra", launch_dat.size(), 16);
        chk("drain_empty", empty, 1);

        // Continuous push/pop of 40 bytes through the timeout path: wrap and order.
        do_reset();
        model_on = 1'b0;
        man_busy = 1'b0;
        nxt      = 0;
        max_cnt  = 0;
        budget   = 400;
        while (launch_dat.size() < 40 && budget > 0) begin
            acc      = 1'b0;
            wr_valid = 1'b0;
            if (nxt < 40) begin
                wr_valid = 1'b1;
                wr_data  = 8'(nxt);
                acc      = wr_ready;
            end
            step();
            if (acc) nxt++;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            budget--;
        end
        wr_valid = 1'b0;
        chk("wrap_launch_count", launch_dat.size(), 40);
        if (launch_dat.size() == 40) begin
            for (int i = 0; i < 40; i++) begin
                chk($sformatf("wrap_data%0d", i), launch_dat[i], 8'(i));
            end
        end
        chk("wrap_max_count", max_cnt, 16);

        // Reset with 5 stored bytes while waiting for busy to fall.
        do_reset();
        busy_left = 0;
        model_on  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hC0 + 8'(i);
            step();
        end
        wr_valid = 1'b0;
        chk("pre_reset_count", count, 5);
        chk("pre_reset_busy", tx_busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_tx_data", tx_data, 8'h00);
        chk("midrst_tx_start", tx_start, 0);
        launch_dat.delete();
        launch_cyc.delete();
        for (int i = 0; i < 30; i++) step();
        chk("midrst_no_launch", launch_dat.size(), 0);
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        step();
        wr_valid = 1'b0;
        wait_launches(1, 40, "post_rst_launch");
        if (launch_dat.size() == 1) chk("post_rst_data", launch_dat[0], 8'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer placed directly upstream of the UART transmitter. Accepts bytes from the host side over a valid/ready handshake, stores up to DEPTH of them in order, and launches them one at a time into the transmitter with a start pulse, waiting for the transmitter's busy signal to drop before sending the next byte. It decouples bursty host writes from the 9600-baud serial line and reports fill level and overflow.

## Interface
- DATA_W, 8, byte width
- DEPTH, 16, FIFO entries; power of two, ≥2
- ADDR_W, log2(DEPTH), derived pointer width
- ACK_TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_start before treating the byte as sent
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_data  in  DATA_W  byte from host
- wr_valid  in  1  host has a byte
- wr_ready  out  1  FIFO can accept; equals !full
- clr_ovf  in  1  clears overflow
- tx_data  out  DATA_W  byte presented to transmitter; held stable until next launch
- tx_start  out  1  one-cycle launch pulse to transmitter
- tx_busy  in  1  transmitter is shifting a frame
- count  out  ADDR_W+1  entries currently stored
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: write attempted while full

## Operation
- Push: wr_valid && wr_ready writes wr_data at wr_ptr, wr_ptr++ (wraps at DEPTH).
- wr_valid && full: byte dropped, overflow set. clr_ovf clears; set wins if both in same cycle.
- Pointers ADDR_W bits, wrap modulo DEPTH; count tracked separately as ADDR_W+1 bits, so full and empty are never ambiguous.
- Launch FSM:
  - IDLE: if !empty && !tx_busy → pop head into tx_data, rd_ptr++, tx_start=1, timer=0, go WAIT_RISE.
  - WAIT_RISE: tx_start=0; if tx_busy → WAIT_FALL; else timer++, at timer==ACK_TIMEOUT-1 → IDLE.
  - WAIT_FALL: when !tx_busy → IDLE.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push when full and pop in the same cycle: push rejected (wr_ready is registered !full, no bypass).
- Reset outputs: tx_data=0x00, tx_start=0, count=0, empty=1, full=0, wr_ready=1, overflow=0; FSM IDLE, pointers 0.
- Reset mid-operation: all stored bytes discarded; an in-flight frame in the transmitter is not affected.

## Timing
- All outputs registered except wr_ready (= !full, from register).
- Push in cycle N → count/empty updated at N+1.
- Earliest launch: byte pushed into empty FIFO at N, tx_start high at N+2 with tx_data valid the same cycle.
- Back-to-back: next tx_start no earlier than 1 cycle after tx_busy is seen low in WAIT_FALL (IDLE re-evaluates).
- Timeout path: without busy response, next launch is ACK_TIMEOUT+1 cycles after previous tx_start.
- tx_start never asserted on two consecutive cycles.

## Structure
- Shared package uart_pkg: UART_DATA_W=8, FSM state enum (IDLE, WAIT_RISE, WAIT_FALL), default DEPTH and ACK_TIMEOUT constants.
- One sub-module: sync_fifo_mem (DEPTH×DATA_W register array, one write port, one asynchronous read port at rd_ptr). Pointers, count, flags, FSM in top.

## Test plan
- Reset, then push 0x55 with tx_busy held low → tx_start pulses at 2nd cycle after push with tx_data=0x55; timeout returns to IDLE; empty=1.
- Push 0x41,0x42,0x43 in consecutive cycles; model raises tx_busy 1 cycle after tx_start, lowers after 10 cycles → three launches in order 0x41,0x42,0x43, each only after busy fell.
- Push 17 bytes into DEPTH=16 with tx_busy stuck high → count=16, full=1, wr_ready=0, overflow=1 after 17th; clr_ovf → overflow=0; 17th byte never appears on tx_data.
- Fill/drain with continuous push and pop for 40 bytes (incrementing 0x00..0x27) → pointer wrap, output order exact, count never exceeds 16.
- Assert reset while count=5 and FSM in WAIT_FALL → next cycle count=0, empty=1, tx_data=0x00, tx_start=0; no further launches until new push.
- Simultaneous push and pop at count=1 → count stays 1.
